design1_wrapper: RTL and testbench
==================================

DESIGN1_WRAPPER -- requirements
Module: design1_wrapper

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h4000_0000, meaning the base of the 4 KB register window.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the AXI address width.
REQ-003 The block SHALL have these ports (clock and reset first): aclk input 1, sole clock, all logic rising-edge; areset input 1, asynchronous active-high reset.
REQ-004 The block SHALL have these AXI4-Lite slave ports: s_axi_awaddr/awvalid/awready, s_axi_wdata(32)/wstrb(4)/wvalid/wready, s_axi_bresp(2)/bvalid/bready, s_axi_araddr/arvalid/arready, s_axi_rdata(32)/rresp(2)/rvalid/rready, with standard AXI4-Lite directions and meanings.
REQ-005 The block SHALL have led_0 output 8, LED register value; sw_0 input 8, switch inputs.

Function
REQ-006 Address decode SHALL use offset = addr - BASE_ADDR, word-aligned, with addr[1:0] ignored; offset 0x0 is LED (RW) and offset 0x4 is SW (RO).
REQ-007 Addresses outside [BASE_ADDR, BASE_ADDR+0xFFF] and unmapped offsets SHALL respond SLVERR, with writes having no effect and reads returning rdata 0.
REQ-008 The write channel SHALL capture AW and W independently, in any order or the same cycle: awready is high while AW is not yet captured and bvalid is low; wready is high while W is not yet captured and bvalid is low.
REQ-009 bvalid SHALL assert the cycle after both AW and W are captured, hold until bready, and clear on the bvalid&bready cycle; there SHALL be one outstanding write.
REQ-010 A write to 0x0 SHALL update led_0 = wdata[7:0] when wstrb[0]=1, visible on led_0 the same cycle bvalid asserts, with bresp OKAY; wstrb[0]=0 SHALL leave the LED register unchanged, still OKAY.
REQ-011 A write to 0x4 SHALL return SLVERR and change nothing.
REQ-012 arready SHALL be high when rvalid is low; after the AR handshake, rvalid SHALL assert the next cycle with rdata latched, hold stable until rready, and there SHALL be one outstanding read.
REQ-013 Read of 0x0 SHALL return {24'h0, led_0} with OKAY; read of 0x4 SHALL return {24'h0, sw value} with OKAY (see REQ-018).
REQ-014 Read and write channels SHALL be independent; a simultaneous write to 0x0 and read of 0x0 SHALL return the pre-write value.
REQ-015 Outputs SHALL hold stable while valid is high and ready is low.

Reset
REQ-016 While areset=1, asynchronously: led_0=8'h00, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0, captured-AW/W flags cleared.
REQ-017 Reset asserted mid-transaction SHALL abort it, with no response issued; after deassertion, the ready signals SHALL assert from the first rising edge.

Configuration
REQ-018 Macro SW_SYNC_EN: when defined, sw_0 SHALL pass through a 2-flop synchronizer (reset 8'h00) and reads of 0x4 SHALL return the synchronized value, i.e. a sw_0 change is visible to reads latched 2 or more cycles later; when undefined, rdata SHALL capture sw_0 directly at the AR handshake.

Verification
REQ-019 Reset held 5 cycles, then released -> led_0=00, bvalid=rvalid=0, and awready/wready/arready high next edge.
REQ-020 Write 0x4000_0000 data 0x55 then 0xAA, wstrb F -> bresp OKAY both, led_0=0x55 then 0xAA.
REQ-021 sw_0=0x44 held 3 or more cycles, read 0x4000_0004 -> rdata 0x44 OKAY; then sw_0=0xBB, read -> rdata 0xBB.
REQ-022 W presented 3 cycles before AW to 0x4000_0000 data 0x12 -> single bresp OKAY, led_0=0x12; bready held low 4 cycles -> bvalid stays high and no new AW accepted.
REQ-023 Write 0x4000_0004 data 0xFF -> SLVERR, led_0 unchanged; read 0x4000_0010 -> SLVERR, rdata 0; read 0x4000_0000 after writing 0xAA -> 0x0000_00AA.
REQ-024 areset pulsed while bvalid pending -> bvalid drops immediately, led_0=00.

Source files
------------

// File: rtl/design1_wrapper.sv
// AXI4-Lite slave exposing an 8-bit LED register (offset 0x0, RW) and switch inputs (offset 0x4, RO).
// Optional macro SW_SYNC_EN routes sw_0 through a 2-flop synchronizer before it is read.
module design1_wrapper #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [7:0]            led_0,
   input  logic [7:0]            sw_0
);

   localparam logic [1:0]            RespOkay  = 2'b00;
   localparam logic [1:0]            RespSlverr = 2'b10;
   localparam logic [ADDR_WIDTH-1:0] WordMask  = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] LedOffset = '0;
   localparam logic [ADDR_WIDTH-1:0] SwOffset  = ADDR_WIDTH'(4);

   logic                  readyEnQ;
   logic                  awCapQ, awCapD;
   logic [ADDR_WIDTH-1:0] awAddrQ, awAddrD;
   logic                  wCapQ, wCapD;
   logic [7:0]            wDataQ, wDataD;
   logic                  wStrb0Q, wStrb0D;
   logic                  bvalidQ, bvalidD;
   logic [1:0]            brespQ, brespD;
   logic [7:0]            ledQ, ledD;
   logic                  rvalidQ, rvalidD;
   logic [31:0]           rdataQ, rdataD;
   logic [1:0]            rrespQ, rrespD;
   logic [7:0]            swValue;

   logic                  awHs, wHs, arHs;
   logic [ADDR_WIDTH-1:0] writeAddr, writeOffset, readOffset;
   logic [7:0]            writeData;
   logic                  writeStrb0, writeIsLed, readIsLed, readIsSw;
   logic                  unusedBits;

   assign unusedBits = &{1'b0, s_axi_wdata[31:8], s_axi_wstrb[3:1]};

   // Ready signals stay low until the first clock edge after reset is released.
   assign s_axi_awready = readyEnQ & ~awCapQ & ~bvalidQ;
   assign s_axi_wready  = readyEnQ & ~wCapQ & ~bvalidQ;
   assign s_axi_arready = readyEnQ & ~rvalidQ;

   assign awHs = s_axi_awvalid & s_axi_awready;
   assign wHs  = s_axi_wvalid & s_axi_wready;
   assign arHs = s_axi_arvalid & s_axi_arready;

   assign writeAddr   = awCapQ ? awAddrQ : s_axi_awaddr;
   assign writeData   = wCapQ ? wDataQ : s_axi_wdata[7:0];
   assign writeStrb0  = wCapQ ? wStrb0Q : s_axi_wstrb[0];
   // Masked offset compares also reject anything outside the 4 KB window.
   assign writeOffset = writeAddr - BASE_ADDR;
   assign readOffset  = s_axi_araddr - BASE_ADDR;
   assign writeIsLed  = (writeOffset & WordMask) == LedOffset;
   assign readIsLed   = (readOffset & WordMask) == LedOffset;
   assign readIsSw    = (readOffset & WordMask) == SwOffset;

`ifdef SW_SYNC_EN
   logic [7:0] swSync1Q, swSync2Q;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         swSync1Q <= 8'h00;
         swSync2Q <= 8'h00;
      end else begin
         swSync1Q <= sw_0;
         swSync2Q <= swSync1Q;
      end
   end

   assign swValue = swSync2Q;
`else
   assign swValue = sw_0;
`endif

   always_comb begin
      awCapD  = awCapQ;
      awAddrD = awAddrQ;
      wCapD   = wCapQ;
      wDataD  = wDataQ;
      wStrb0D = wStrb0Q;
      bvalidD = bvalidQ;
      brespD  = brespQ;
      ledD    = ledQ;
      if (awHs) begin
         awCapD  = 1'b1;
         awAddrD = s_axi_awaddr;
      end
      if (wHs) begin
         wCapD   = 1'b1;
         wDataD  = s_axi_wdata[7:0];
         wStrb0D = s_axi_wstrb[0];
      end
      if (bvalidQ) begin
         if (s_axi_bready) bvalidD = 1'b0;
      end else if (awCapD && wCapD) begin
         bvalidD = 1'b1;
         awCapD  = 1'b0;
         wCapD   = 1'b0;
         if (writeIsLed) begin
            if (writeStrb0) ledD = writeData;
            brespD = RespOkay;
         end else begin
            brespD = RespSlverr;
         end
      end
   end

   always_comb begin
      rvalidD = rvalidQ & ~s_axi_rready;
      rdataD  = rdataQ;
      rrespD  = rrespQ;
      if (arHs) begin
         rvalidD = 1'b1;
         if (readIsLed) begin
            rdataD = {24'h0, ledQ};
            rrespD = RespOkay;
         end else if (readIsSw) begin
            rdataD = {24'h0, swValue};
            rrespD = RespOkay;
         end else begin
            rdataD = 32'h0;
            rrespD = RespSlverr;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         readyEnQ <= 1'b0;
         awCapQ   <= 1'b0;
         awAddrQ  <= '0;
         wCapQ    <= 1'b0;
         wDataQ   <= 8'h00;
         wStrb0Q  <= 1'b0;
         bvalidQ  <= 1'b0;
         brespQ   <= RespOkay;
         ledQ     <= 8'h00;
         rvalidQ  <= 1'b0;
         rdataQ   <= 32'h0;
         rrespQ   <= RespOkay;
      end else begin
         readyEnQ <= 1'b1;
         awCapQ   <= awCapD;
         awAddrQ  <= awAddrD;
         wCapQ    <= wCapD;
         wDataQ   <= wDataD;
         wStrb0Q  <= wStrb0D;
         bvalidQ  <= bvalidD;
         brespQ   <= brespD;
         ledQ     <= ledD;
         rvalidQ  <= rvalidD;
         rdataQ   <= rdataD;
         rrespQ   <= rrespD;
      end
   end

   assign s_axi_bvalid = bvalidQ;
   assign s_axi_bresp  = brespQ;
   assign s_axi_rvalid = rvalidQ;
   assign s_axi_rdata  = rdataQ;
   assign s_axi_rresp  = rrespQ;
   assign led_0        = ledQ;

endmodule

// File: tb/tb_design1_wrapper.sv
// Self-checking bench for design1_wrapper: vector table, corner-case sequences and
// randomized traffic against a register-level reference model.
module tb_design1_wrapper;

   localparam logic [31:0] Base = 32'h4000_0000;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [31:0] s_axi_awaddr = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic [31:0] s_axi_araddr = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic [7:0]  led_0;
   logic [7:0]  sw_0 = 8'h00;

   int assertCount = 0;
   int failCount = 0;
   logic [7:0] ledModel = 8'h00;

   always #5 aclk = ~aclk;

   design1_wrapper #(.ADDR_WIDTH(32), .BASE_ADDR(Base)) dut (
      .aclk(aclk), .areset(areset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .led_0(led_0), .sw_0(sw_0)
   );

   typedef struct {
      bit          isWrite;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [7:0]  sw;
      logic [1:0]  expResp;
      logic [31:0] expRdata;
      logic [7:0]  expLed;
   } vecT;

   vecT vecs[13];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [7:0] ledSeen);
      bit awDone = 0, wDone = 0, gotB = 0, sAw, sW;
      int cycles = 0;
      s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
      while (!(awDone && wDone) && cycles < 50) begin
         @(negedge aclk);
         sAw = s_axi_awvalid && s_axi_awready;
         sW  = s_axi_wvalid && s_axi_wready;
         @(posedge aclk); #1;
         if (sAw) begin s_axi_awvalid = 1'b0; awDone = 1; end
         if (sW) begin s_axi_wvalid = 1'b0; wDone = 1; end
         cycles++;
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      checkOutput("write addr/data accepted", {30'h0, awDone, wDone}, 32'h3);
      s_axi_bready = 1'b1;
      resp = 2'bxx; ledSeen = 8'hxx;
      cycles = 0;
      while (!gotB && cycles < 50) begin
         @(negedge aclk);
         if (s_axi_bvalid) begin gotB = 1; resp = s_axi_bresp; ledSeen = led_0; end
         @(posedge aclk); #1;
         cycles++;
      end
      s_axi_bready = 1'b0;
      checkOutput("write response seen", {31'h0, gotB}, 32'h1);
   endtask

   task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit arDone = 0, gotR = 0, sAr;
      int cycles = 0;
      s_axi_araddr = addr; s_axi_arvalid = 1'b1;
      while (!arDone && cycles < 50) begin
         @(negedge aclk);
         sAr = s_axi_arvalid && s_axi_arready;
         @(posedge aclk); #1;
         if (sAr) begin s_axi_arvalid = 1'b0; arDone = 1; end
         cycles++;
      end
      s_axi_arvalid = 1'b0;
      checkOutput("read addr accepted", {31'h0, arDone}, 32'h1);
      s_axi_rready = 1'b1;
      data = 'x; resp = 2'bxx;
      cycles = 0;
      while (!gotR && cycles < 50) begin
         @(negedge aclk);
         if (s_axi_rvalid) begin gotR = 1; data = s_axi_rdata; resp = s_axi_rresp; end
         @(posedge aclk); #1;
         cycles++;
      end
      s_axi_rready = 1'b0;
      checkOutput("read response seen", {31'h0, gotR}, 32'h1);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic applyStimulus(input int idx, input vecT v);
      logic [1:0]  resp;
      logic [7:0]  ledSeen;
      logic [31:0] rdata;
      sw_0 = v.sw;
      waitCycles(3);
      if (v.isWrite) begin
         axiWrite(v.addr, v.data, v.strb, resp, ledSeen);
         checkOutput($sformatf("vec%0d bresp", idx), {30'h0, resp}, {30'h0, v.expResp});
         checkOutput($sformatf("vec%0d led", idx), {24'h0, ledSeen}, {24'h0, v.expLed});
      end else begin
         axiRead(v.addr, rdata, resp);
         checkOutput($sformatf("vec%0d rresp", idx), {30'h0, resp}, {30'h0, v.expResp});
         checkOutput($sformatf("vec%0d rdata", idx), rdata, v.expRdata);
         checkOutput($sformatf("vec%0d led", idx), {24'h0, led_0}, {24'h0, v.expLed});
      end
   endtask

   // Reference: the window is 4 KB from Base; word 0 is the LED register, word 1 the switches.
   function automatic int modelWord(input logic [31:0] addr);
      longint unsigned a = longint'(addr);
      longint unsigned b = longint'(Base);
      if (a < b || a - b >= 4096) return -1;
      return int'((a - b) / 4);
   endfunction

   initial begin
      logic [1:0]  resp;
      logic [7:0]  ledSeen;
      logic [31:0] rdata, addr, data;
      logic [3:0]  strb;
      logic [7:0]  sw;
      int          word;

      vecs[0]  = '{1, Base,                32'h55, 4'hF, 8'h00, 2'b00, 32'h0,  8'h55};
      vecs[1]  = '{1, Base,                32'hAA, 4'hF, 8'h00, 2'b00, 32'h0,  8'hAA};
      vecs[2]  = '{0, Base,                32'h0,  4'h0, 8'h00, 2'b00, 32'hAA, 8'hAA};
      vecs[3]  = '{1, Base + 32'h4,        32'hFF, 4'hF, 8'h00, 2'b10, 32'h0,  8'hAA};
      vecs[4]  = '{0, Base + 32'h10,       32'h0,  4'h0, 8'h00, 2'b10, 32'h0,  8'hAA};
      vecs[5]  = '{0, Base + 32'h4,        32'h0,  4'h0, 8'h44, 2'b00, 32'h44, 8'hAA};
      vecs[6]  = '{0, Base + 32'h4,        32'h0,  4'h0, 8'hBB, 2'b00, 32'hBB, 8'hAA};
      vecs[7]  = '{1, Base,                32'h33, 4'hE, 8'h00, 2'b00, 32'h0,  8'hAA};
      vecs[8]  = '{1, 32'h3FFF_FFFC,       32'h11, 4'hF, 8'h00, 2'b10, 32'h0,  8'hAA};
      vecs[9]  = '{0, Base + 32'h1000,     32'h0,  4'h0, 8'h00, 2'b10, 32'h0,  8'hAA};
      vecs[10] = '{0, Base + 32'h3,        32'h0,  4'h0, 8'h00, 2'b00, 32'hAA, 8'hAA};
      vecs[11] = '{1, Base + 32'h2,        32'h5A, 4'hF, 8'h00, 2'b00, 32'h0,  8'h5A};
      vecs[12] = '{0, Base + 32'hFFC,      32'h0,  4'h0, 8'h00, 2'b10, 32'h0,  8'h5A};

      // Reset held five cycles, then released.
      repeat (5) @(posedge aclk);
      @(negedge aclk);
      checkOutput("reset led", {24'h0, led_0}, 32'h0);
      checkOutput("reset readys", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
      checkOutput("reset valids", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
      checkOutput("reset rdata", s_axi_rdata, 32'h0);
      @(posedge aclk); #1 areset = 1'b0;
      @(posedge aclk); @(negedge aclk);
      checkOutput("post-reset readys", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
      checkOutput("post-reset valids", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
      @(posedge aclk); #1;

      for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);
      ledModel = 8'h5A;

      // W arrives three cycles ahead of AW; then bready held low with a new AW waiting.
      s_axi_wdata = 32'h12; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      @(posedge aclk); #1 s_axi_wvalid = 1'b0;
      @(negedge aclk);
      checkOutput("early W captured, no bvalid", {30'h0, s_axi_wready, s_axi_bvalid}, 32'h0);
      waitCycles(2);
      s_axi_awaddr = Base; s_axi_awvalid = 1'b1;
      @(posedge aclk); #1 s_axi_awvalid = 1'b0;
      @(negedge aclk);
      checkOutput("late AW bvalid", {31'h0, s_axi_bvalid}, 32'h1);
      checkOutput("late AW bresp", {30'h0, s_axi_bresp}, 32'h0);
      checkOutput("late AW led", {24'h0, led_0}, 32'h12);
      ledModel = 8'h12;
      @(posedge aclk); #1;
      s_axi_awaddr = Base; s_axi_awvalid = 1'b1; s_axi_wdata = 32'h66;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         checkOutput($sformatf("bvalid hold %0d", i), {30'h0, s_axi_bvalid, s_axi_awready}, 32'h2);
         @(posedge aclk); #1;
      end
      s_axi_bready = 1'b1;
      @(posedge aclk); #1 s_axi_bready = 1'b0; s_axi_awvalid = 1'b0;
      @(negedge aclk);
      checkOutput("bvalid cleared, AW free", {30'h0, s_axi_bvalid, s_axi_awready}, 32'h1);
      checkOutput("led after held response", {24'h0, led_0}, 32'h12);
      @(posedge aclk); #1;

      // Simultaneous write and read of the LED register; read sees the old value.
      s_axi_awaddr = Base; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      s_axi_araddr = Base; s_axi_arvalid = 1'b1;
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      @(negedge aclk);
      checkOutput("simul rvalid/bvalid", {30'h0, s_axi_rvalid, s_axi_bvalid}, 32'h3);
      checkOutput("simul rdata pre-write", s_axi_rdata, 32'h12);
      checkOutput("simul led post-write", {24'h0, led_0}, 32'h77);
      @(posedge aclk); @(negedge aclk);
      checkOutput("rdata stable while stalled", s_axi_rdata, 32'h12);
      checkOutput("arready low while rvalid", {31'h0, s_axi_arready}, 32'h0);
      @(posedge aclk); #1 s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      @(posedge aclk); #1 s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      ledModel = 8'h77;

      // Randomized traffic against the register model.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: addr = Base + 32'($urandom_range(0, 7));
            1: addr = Base + 32'($urandom_range(0, 4095));
            default: addr = $urandom;
         endcase
         word = modelWord(addr);
         if ($urandom_range(0, 1) == 1) begin
            data = $urandom; strb = 4'($urandom);
            axiWrite(addr, data, strb, resp, ledSeen);
            if (word == 0 && strb[0]) ledModel = data[7:0];
            checkOutput($sformatf("rand%0d bresp @%h", i, addr), {30'h0, resp},
                        (word == 0) ? 32'h0 : 32'h2);
            checkOutput($sformatf("rand%0d led", i), {24'h0, ledSeen}, {24'h0, ledModel});
         end else begin
            sw = 8'($urandom); sw_0 = sw;
            waitCycles(3);
            axiRead(addr, rdata, resp);
            checkOutput($sformatf("rand%0d rresp @%h", i, addr), {30'h0, resp},
                        (word == 0 || word == 1) ? 32'h0 : 32'h2);
            checkOutput($sformatf("rand%0d rdata", i), rdata,
                        (word == 0) ? {24'h0, ledModel} : (word == 1) ? {24'h0, sw} : 32'h0);
         end
      end

      // Reset asserted while a write response is pending.
      s_axi_awaddr = Base; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h99; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      @(posedge aclk); #1 s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      @(negedge aclk);
      checkOutput("pending bvalid before reset", {31'h0, s_axi_bvalid}, 32'h1);
      #1 areset = 1'b1;
      #1;
      checkOutput("bvalid dropped by reset", {31'h0, s_axi_bvalid}, 32'h0);
      checkOutput("led cleared by reset", {24'h0, led_0}, 32'h0);
      @(posedge aclk); #1 areset = 1'b0;
      @(posedge aclk); @(negedge aclk);
      checkOutput("readys after mid reset", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
      checkOutput("no response after mid reset", {31'h0, s_axi_bvalid}, 32'h0);
      @(posedge aclk); #1;
      ledModel = 8'h00;
      axiRead(Base, rdata, resp);
      checkOutput("led read after mid reset", rdata, {24'h0, ledModel});

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
